// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE MAC sequencer and its result serializer.
package pe_pkg;

  localparam int DEF_ACC_W = 24;
  localparam int OUT_BYTES = DEF_ACC_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_A,
    FIRE,
    DRAIN,
    OUT,
    DONE
  } pe_state_t;

endpackage

// File: rtl/pe_result_serializer.sv
// Holds the latched accumulator and streams it LSB byte first over valid/ready.
module pe_result_serializer
  import pe_pkg::*;
#(
  parameter int NBYTES = OUT_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  last
);

  localparam int IDX_W = $clog2(NBYTES + 1);

  logic [NBYTES*8-1:0] shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic                xfer;

  assign xfer     = out_valid && out_ready && ena;
  assign last     = xfer && (idx_q == IDX_W'(NBYTES - 1));
  assign out_data = shift_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset because it drives out_data directly and must read 0 out of reset.
      shift_q   <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
    end else if (load && ena) begin
      shift_q   <= load_data;
      idx_q     <= '0;
      out_valid <= 1'b1;
    end else if (xfer) begin
      shift_q <= shift_q >> 8;
      idx_q   <= idx_q + IDX_W'(1);
      if (last) out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Sequences a K-pair dot product through the signed 8-bit MAC PE and serialises the result.
module pe_mac_sequencer
  import pe_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PE_LAT = 2,
  parameter int K_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             pe_clear,
  output logic             pe_en,
  output logic [7:0]       pe_a,
  output logic [7:0]       pe_b,
  input  logic [ACC_W-1:0] pe_acc,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int LAT_W = $clog2(PE_LAT + 1);

  pe_state_t      state_q, state_d;
  logic [K_W-1:0] kcnt_q;
  logic [LAT_W-1:0] lat_q;
  logic           start_ok;
  logic           in_xfer;
  logic           ser_load;
  logic           ser_last;

  assign start_ok = (state_q == IDLE) && start && ena;
  assign in_xfer  = in_valid && in_ready && ena;
  assign ser_load = (state_q == DRAIN) && (lat_q == '0) && ena;

  // The clear issues in the accepting cycle, so a K=0 job drains an already-cleared accumulator.
  assign pe_clear = start_ok;
  assign pe_en    = (state_q == FIRE) && ena;

  always_comb begin
    // NOTE: defaulting to the current state first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (start) state_d = (k_len == '0) ? DRAIN : LOAD_W;
        LOAD_W:  if (in_xfer) state_d = LOAD_A;
        LOAD_A:  if (in_xfer) state_d = FIRE;
        FIRE:    state_d = (kcnt_q == K_W'(1)) ? DRAIN : LOAD_W;
        DRAIN:   if (lat_q == '0) state_d = OUT;
        OUT:     if (ser_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kcnt_q   <= '0;
      lat_q    <= '0;
      pe_a     <= '0;
      pe_b     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q  <= state_d;
      in_ready <= (state_d == LOAD_W) || (state_d == LOAD_A);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      if (ena) begin
        case (state_q)
          IDLE: if (start) begin
            kcnt_q <= k_len;
            lat_q  <= '0;
          end
          LOAD_W: if (in_xfer) pe_a <= in_data;
          LOAD_A: if (in_xfer) pe_b <= in_data;
          FIRE: begin
            kcnt_q <= kcnt_q - K_W'(1);
            if (kcnt_q == K_W'(1)) lat_q <= LAT_W'(PE_LAT);
          end
          DRAIN: if (lat_q != '0) lat_q <= lat_q - LAT_W'(1);
          default: ;
        endcase
      end
    end
  end

  pe_result_serializer #(
    .NBYTES(ACC_W / 8)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (ser_load),
    .load_data (pe_acc),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .last      (ser_last)
  );

endmodule
